// File: rtl/time_set_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : time_set_pkg                                             |
// | Purpose   : Shared types, encodings and BCD helpers for the          |
// |             time/alarm setting front-end.                            |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package time_set_pkg;

  // State encoding doubles as the edit_field display code.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOUR = 2'd1,
    MIN  = 2'd2,
    LOAD = 2'd3
  } state_e;

  localparam logic TGT_TIME  = 1'b0;
  localparam logic TGT_ALARM = 1'b1;

  localparam logic [1:0] HOUR_MAX_H1 = 2'd2;
  localparam logic [3:0] HOUR_MAX_H0 = 4'd3;
  localparam logic [2:0] MIN_MAX_M1  = 3'd5;
  localparam logic [3:0] DIGIT_MAX   = 4'd9;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
  } hour_t;

  typedef struct packed {
    logic [2:0] m1;
    logic [3:0] m0;
  } min_t;

  // BCD hour step, 23 wraps to 00.
  function automatic hour_t hour_inc(input hour_t h);
    hour_t r;
    r = h;
    if (h.h1 == HOUR_MAX_H1 && h.h0 == HOUR_MAX_H0) begin
      r = '0;
    end else if (h.h0 == DIGIT_MAX) begin
      r.h0 = 4'd0;
      r.h1 = h.h1 + 2'd1;
    end else begin
      r.h0 = h.h0 + 4'd1;
    end
    return r;
  endfunction

  // BCD minute step, 59 wraps to 00.
  function automatic min_t min_inc(input min_t m);
    min_t r;
    r = m;
    if (m.m1 == MIN_MAX_M1 && m.m0 == DIGIT_MAX) begin
      r = '0;
    end else if (m.m0 == DIGIT_MAX) begin
      r.m0 = 4'd0;
      r.m1 = m.m1 + 3'd1;
    end else begin
      r.m0 = m.m0 + 4'd1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_ctrl_btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : btn_debounce                                             |
// | Purpose   : 2-FF synchroniser, counting debouncer and press pulse    |
// |             for one raw push-button.                                 |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module btn_debounce #(
  parameter int DEB_CYC = 3
) (
  input  logic clk,
  input  logic rst_bar,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYC) + 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips only after DEB_CYC consecutive differing samples; the press
  // pulse is registered alongside the rising level so both appear together.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYC - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser and debouncer state.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : time_set_ctrl                                            |
// | Purpose   : Button-driven editor producing BCD digits and held       |
// |             load_time / load_alarm strobes for the alarm clock core. |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEB_CYC     = 3,
  parameter int LOAD_HOLD   = 120,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 20,
  parameter int EDIT_TMO    = 3000
) (
  input  logic       clk,
  input  logic       rst_bar,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_enter,
  output logic [1:0] h1_in,
  output logic [3:0] h0_in,
  output logic [2:0] m1_in,
  output logic [3:0] m0_in,
  output logic       load_time,
  output logic       load_alarm,
  output logic [1:0] edit_field,
  output logic       edit_target
);

  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX) + 1;
  localparam int TW      = $clog2(EDIT_TMO) + 1;
  localparam int LW      = $clog2(LOAD_HOLD) + 1;

  logic mode_p, inc_p, enter_p;
  logic mode_lvl, inc_lvl, enter_lvl;
  logic unused_lvl;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .clk(clk), .rst_bar(rst_bar), .btn_raw(btn_mode), .level(mode_lvl), .press(mode_p)
  );
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc (
    .clk(clk), .rst_bar(rst_bar), .btn_raw(btn_inc), .level(inc_lvl), .press(inc_p)
  );
  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_enter (
    .clk(clk), .rst_bar(rst_bar), .btn_raw(btn_enter), .level(enter_lvl), .press(enter_p)
  );

  // Only the press events of mode/enter matter; their held levels are not used.
  assign unused_lvl = mode_lvl ^ enter_lvl;

  state_e        state_q, state_d;
  logic          target_q, target_d;
  hour_t         hour_q, hour_d;
  min_t          min_q, min_d;
  logic          load_time_q, load_time_d;
  logic          load_alarm_q, load_alarm_d;
  logic [LW-1:0] load_cnt_q, load_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d, tmo_next;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_armed_q, rpt_armed_d;
  logic          editing, rpt_fire, inc_act;

  assign editing  = (state_q == HOUR) || (state_q == MIN);
  // rpt_cnt_q == 0 means no repeat sequence is running; otherwise it counts
  // cycles since the last press/repeat, against the first-delay or rate limit.
  assign rpt_fire = editing && inc_lvl && (rpt_cnt_q != '0) &&
                    (rpt_cnt_q == (rpt_armed_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DLY)));
  assign inc_act  = inc_p | rpt_fire;
  assign tmo_next = tmo_cnt_q + TW'(1);

  // Next-state logic: event priority mode > enter > inc, then timeout and repeat.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    hour_d       = hour_q;
    min_d        = min_q;
    load_time_d  = 1'b0;
    load_alarm_d = 1'b0;
    load_cnt_d   = '0;
    tmo_cnt_d    = '0;
    rpt_cnt_d    = '0;
    rpt_armed_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mode_p) begin
          state_d  = HOUR;
          target_d = TGT_TIME;
        end else if (enter_p) begin
          state_d  = HOUR;
          target_d = TGT_ALARM;
        end
      end
      HOUR: begin
        if (mode_p)        state_d = IDLE;
        else if (enter_p)  state_d = MIN;
        else if (inc_act)  hour_d  = hour_inc(hour_q);
      end
      MIN: begin
        if (mode_p) begin
          state_d = IDLE;
        end else if (enter_p) begin
          state_d      = LOAD;
          load_time_d  = (target_q == TGT_TIME);
          load_alarm_d = (target_q == TGT_ALARM);
        end else if (inc_act) begin
          min_d = min_inc(min_q);
        end
      end
      LOAD: begin
        if (load_cnt_q == LW'(LOAD_HOLD - 1)) begin
          state_d = IDLE;
        end else begin
          load_cnt_d   = load_cnt_q + LW'(1);
          load_time_d  = load_time_q;
          load_alarm_d = load_alarm_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Inactivity timeout while editing; any event restarts it.
    if (editing && state_d == state_q) begin
      if (mode_p || enter_p || inc_p || rpt_fire) begin
        tmo_cnt_d = '0;
      end else if (tmo_next == TW'(EDIT_TMO)) begin
        state_d = IDLE;
      end else begin
        tmo_cnt_d = tmo_next;
      end
    end

    // Auto-repeat sequencing; cleared on release or any state change.
    if (editing && state_d == state_q && inc_lvl) begin
      if (inc_p) begin
        rpt_cnt_d = RW'(1);
      end else if (rpt_fire) begin
        rpt_cnt_d   = RW'(1);
        rpt_armed_d = 1'b1;
      end else if (rpt_cnt_q != '0) begin
        rpt_cnt_d   = rpt_cnt_q + RW'(1);
        rpt_armed_d = rpt_armed_q;
      end
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q      <= IDLE;
      target_q     <= TGT_TIME;
      hour_q       <= '0;
      min_q        <= '0;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;
      load_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      rpt_cnt_q    <= '0;
      rpt_armed_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      load_time_q  <= load_time_d;
      load_alarm_q <= load_alarm_d;
      load_cnt_q   <= load_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      rpt_cnt_q    <= rpt_cnt_d;
      rpt_armed_q  <= rpt_armed_d;
    end
  end

  assign h1_in       = hour_q.h1;
  assign h0_in       = hour_q.h0;
  assign m1_in       = min_q.m1;
  assign m0_in       = min_q.m0;
  assign load_time   = load_time_q;
  assign load_alarm  = load_alarm_q;
  assign edit_field  = state_q;
  assign edit_target = target_q;

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_time_set_ctrl                                         |
// | Purpose   : Scoreboard bench for time_set_ctrl: directed button      |
// |             sequences, expected snapshots and load transactions.     |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_bar = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_enter = 1'b0;
  logic [1:0] h1_in;
  logic [3:0] h0_in;
  logic [2:0] m1_in;
  logic [3:0] m0_in;
  logic       load_time, load_alarm;
  logic [1:0] edit_field;
  logic       edit_target;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .DEB_CYC(3), .LOAD_HOLD(120), .REPEAT_DLY(50), .REPEAT_RATE(20), .EDIT_TMO(3000)
  ) dut (
    .clk(clk), .rst_bar(rst_bar),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_enter(btn_enter),
    .h1_in(h1_in), .h0_in(h0_in), .m1_in(m1_in), .m0_in(m0_in),
    .load_time(load_time), .load_alarm(load_alarm),
    .edit_field(edit_field), .edit_target(edit_target)
  );

  typedef struct packed {
    int ef; int tgt; int h1; int h0; int m1; int m0; int lt; int la;
  } snap_t;
  typedef struct packed {
    logic alarm; logic [3:0] h1; logic [3:0] h0; logic [3:0] m1; logic [3:0] m0;
  } load_t;

  snap_t snap_q[$];
  string name_q[$];
  load_t load_q[$];
  int    tests = 0;
  int    fails = 0;

  snap_t se;
  string sn;
  load_t cur;
  bit    active = 1'b0, have = 1'b0, bad = 1'b0;
  int    len = 0;

  // Monitor: pops snapshots and tracks each load strobe as one transaction.
  always @(posedge clk) begin
    #1;
    while (snap_q.size() > 0) begin
      se = snap_q.pop_front();
      sn = name_q.pop_front();
      tests++;
      if (edit_field !== se.ef[1:0] || (se.tgt >= 0 && edit_target !== se.tgt[0]) ||
          h1_in !== se.h1[1:0] || h0_in !== se.h0[3:0] || m1_in !== se.m1[2:0] ||
          m0_in !== se.m0[3:0] || load_time !== se.lt[0] || load_alarm !== se.la[0]) begin
        fails++;
        $display("FAIL %s: got ef=%0d tgt=%0d %0d%0d:%0d%0d lt=%0d la=%0d, expected ef=%0d tgt=%0d %0d%0d:%0d%0d lt=%0d la=%0d",
                 sn, edit_field, edit_target, h1_in, h0_in, m1_in, m0_in, load_time, load_alarm,
                 se.ef, se.tgt, se.h1, se.h0, se.m1, se.m0, se.lt, se.la);
      end
    end
    if (!rst_bar) begin
      active = 1'b0;
    end else if (load_time || load_alarm) begin
      if (!active) begin
        active = 1'b1; len = 0; bad = 1'b0; have = 1'b0;
        if (load_q.size() > 0) begin
          cur = load_q.pop_front();
          have = 1'b1;
        end
      end
      len++;
      if (have && (load_time === cur.alarm || load_alarm !== cur.alarm ||
                   h1_in !== cur.h1[1:0] || h0_in !== cur.h0 || m1_in !== cur.m1[2:0] ||
                   m0_in !== cur.m0 || edit_field !== 2'd3))
        bad = 1'b1;
    end else if (active) begin
      active = 1'b0;
      tests++;
      if (!have || bad || len != 120) begin
        fails++;
        $display("FAIL load_strobe: expected_present=%0d wrong_value_seen=%0d length=%0d, required present, no wrong value, length 120",
                 have, bad, len);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    if (b == 0) btn_mode = v;
    else if (b == 1) btn_inc = v;
    else btn_enter = v;
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    tick(8);
    set_btn(b, 1'b0);
    tick(8);
  endtask

  task automatic inc_n(input int n);
    repeat (n) press(1);
  endtask

  task automatic snap(input string n, input int ef, input int tgt, input int h1, input int h0,
                      input int m1, input int m0, input int lt, input int la);
    snap_q.push_back('{ef, tgt, h1, h0, m1, m0, lt, la});
    name_q.push_back(n);
    tick(2);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (edit_field != 2'd0 && k < 300) begin
      tick(1);
      k++;
    end
    if (edit_field != 2'd0) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: edit_field=%0d, required 0 within 300 cycles", edit_field);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset at start and after release
    tick(3);
    snap("reset_low", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_bar = 1'b1;
    tick(2);
    snap("reset_release", 0, 0, 0, 0, 0, 0, 0, 0);

    // Bounce rejection in HOUR
    press(0);
    snap("enter_hour_time", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      btn_inc = ~btn_inc;
      tick(1);
    end
    btn_inc = 1'b1;
    tick(10);
    btn_inc = 1'b0;
    tick(8);
    snap("bounce_one_inc", 1, 0, 0, 1, 0, 0, 0, 0);

    // Mid-run reset
    rst_bar = 1'b0;
    tick(1);
    snap("reset_mid_low", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_bar = 1'b1;
    tick(1);
    snap("reset_mid_release", 0, 0, 0, 0, 0, 0, 0, 0);

    // Time load with hour and minute wrap-around
    press(0);
    snap("time_hour_entry", 1, 0, 0, 0, 0, 0, 0, 0);
    inc_n(23);
    snap("hour_23", 1, 0, 2, 3, 0, 0, 0, 0);
    inc_n(1);
    snap("hour_wrap", 1, 0, 0, 0, 0, 0, 0, 0);
    inc_n(23);
    press(2);
    snap("time_min_entry", 2, 0, 2, 3, 0, 0, 0, 0);
    inc_n(59);
    snap("min_59", 2, 0, 2, 3, 5, 9, 0, 0);
    load_q.push_back('{1'b0, 4'd2, 4'd3, 4'd5, 4'd9});
    press(2);
    wait_idle();
    snap("after_time_load", 0, -1, 2, 3, 5, 9, 0, 0);

    // Alarm path: 23:59 -> 06:30
    press(2);
    snap("alarm_target", 1, 1, 2, 3, 5, 9, 0, 0);
    inc_n(7);
    snap("alarm_hour_06", 1, 1, 0, 6, 5, 9, 0, 0);
    press(2);
    inc_n(31);
    snap("alarm_min_30", 2, 1, 0, 6, 3, 0, 0, 0);
    load_q.push_back('{1'b1, 4'd0, 4'd6, 4'd3, 4'd0});
    press(2);
    wait_idle();
    snap("after_alarm_load", 0, -1, 0, 6, 3, 0, 0, 0);

    // Abort from MIN: no strobe must appear
    press(2);
    press(2);
    inc_n(1);
    press(0);
    snap("abort_min", 0, -1, 0, 6, 3, 1, 0, 0);
    tick(150);
    snap("abort_no_strobe", 0, -1, 0, 6, 3, 1, 0, 0);

    // Auto-repeat in MIN from 00
    press(0);
    press(2);
    inc_n(29);
    snap("min_zero", 2, 0, 0, 6, 0, 0, 0, 0);
    btn_inc = 1'b1;
    tick(136);
    btn_inc = 1'b0;
    tick(10);
    snap("auto_repeat", 2, 0, 0, 6, 0, 6, 0, 0);

    // Timeout in HOUR
    press(0);
    snap("back_idle", 0, -1, 0, 6, 0, 6, 0, 0);
    press(0);
    tick(2980);
    snap("before_timeout", 1, 0, 0, 6, 0, 6, 0, 0);
    tick(20);
    snap("after_timeout", 0, -1, 0, 6, 0, 6, 0, 0);

    // Same-cycle priority
    press(0);
    btn_mode = 1'b1; btn_inc = 1'b1;
    tick(8);
    btn_mode = 1'b0; btn_inc = 1'b0;
    tick(8);
    snap("prio_mode_over_inc", 0, -1, 0, 6, 0, 6, 0, 0);
    press(0);
    btn_enter = 1'b1; btn_inc = 1'b1;
    tick(8);
    btn_enter = 1'b0; btn_inc = 1'b0;
    tick(8);
    snap("prio_enter_over_inc", 2, 0, 0, 6, 0, 6, 0, 0);
    press(0);
    snap("final_idle", 0, -1, 0, 6, 0, 6, 0, 0);

    tick(5);
    tests++;
    if (load_q.size() != 0) begin
      fails++;
      $display("FAIL load_queue_drained: %0d pending, required 0", load_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Upstream front-end for the alarm clock core. Converts three raw push-buttons (mode, inc, enter) into BCD hour/minute digits and the load_time / load_alarm strobes that the core consumes. The core samples its inputs on the falling edge of its internal 1 Hz tick, so this block holds digits and the load strobe stable for a parameterised window longer than one tick period. Runs on the same 100 Hz system clock.

Parameters:
DEB_CYC, 3, consecutive identical synchronised samples required to change a debounced button level.
LOAD_HOLD, 120, cycles load_time/load_alarm stay high; must exceed 100 (one 1 Hz period).
REPEAT_DLY, 50, cycles inc must be held after its press event before the first auto-repeat.
REPEAT_RATE, 20, cycles between subsequent auto-repeats.
EDIT_TMO, 3000, cycles without any press event in HOUR/MIN before the edit is aborted (30 s).

Ports:
clk  in  1  100 Hz system clock; all state on posedge.
rst_bar  in  1  asynchronous, active-low reset.
btn_mode  in  1  raw button, active high, asynchronous to clk.
btn_inc  in  1  raw button, active high, asynchronous to clk.
btn_enter  in  1  raw button, active high, asynchronous to clk.
h1_in  out  2  hour tens digit (0-2), feeds the core's h1_in.
h0_in  out  4  hour units digit (0-9), feeds the core's h0_in.
m1_in  out  3  minute tens digit (0-5), feeds the core's m1_in.
m0_in  out  4  minute units digit (0-9), feeds the core's m0_in.
load_time  out  1  high for LOAD_HOLD cycles to commit clock time.
load_alarm  out  1  high for LOAD_HOLD cycles to commit alarm time.
edit_field  out  2  0 = IDLE, 1 = HOUR, 2 = MIN, 3 = LOAD, for display blinking.
edit_target  out  1  0 = time, 1 = alarm; valid while edit_field != 0.

Behaviour:
- Reset (async): all outputs 0, digits 00:00, FSM IDLE, all counters 0, debounced levels 0. Reset asserted mid-LOAD drops the load strobe immediately.
- Input path per button: 2-FF synchroniser, then debouncer. The debounced level flips after DEB_CYC consecutive samples that differ from it; any differing sample restarts the count. A press event is a 1-cycle pulse on the debounced rising edge. Latency from a clean raw edge to the press event is 2 + DEB_CYC cycles.
- Same-cycle priority: mode > enter > inc. Only the highest-priority event acts.
- FSM:
  - IDLE: mode -> HOUR with target = time. enter -> HOUR with target = alarm. inc is ignored.
  - HOUR: inc -> hour + 1. enter -> MIN. mode -> IDLE (abort, no load).
  - MIN: inc -> minute + 1. enter -> LOAD. mode -> IDLE (abort).
  - LOAD: the strobe selected by target is high for exactly LOAD_HOLD cycles, starting the cycle after entry. The other strobe stays 0. Digits are frozen. All buttons are ignored. Then IDLE.
- Digit registers retain their last value across edits and aborts. They change only on inc and reset.
- Hour increment (BCD): 23 -> 00; h0 = 9 -> h0 = 0, h1 + 1; else h0 + 1.
- Minute increment: 59 -> 00; m0 = 9 -> m0 = 0, m1 + 1; else m0 + 1.
- Illegal digits are never produced.
- Auto-repeat (HOUR/MIN only):
  - While debounced inc stays high, an extra increment fires REPEAT_DLY cycles after the press event, then every REPEAT_RATE cycles.
  - Release, or any state change, clears the repeat counter.
- Timeout: in HOUR/MIN the counter resets on every press event or auto-repeat. When it reaches EDIT_TMO the FSM goes to IDLE with no load.
- Counter widths use $clog2 of the relevant parameter + 1.

Decomposition:
- Package time_set_pkg holds:
  - the state enum (IDLE, HOUR, MIN, LOAD), whose encoding equals edit_field;
  - target encodings;
  - BCD limits HOUR_MAX_H1 = 2, HOUR_MAX_H0 = 3, MIN_MAX_M1 = 5, DIGIT_MAX = 9.
- Sub-module btn_debounce (synchroniser + debouncer + press pulse, parameter DEB_CYC), instantiated three times.

Test Plan:
1. Reset check: pulse rst_bar low mid-run -> all outputs 0, digits 00:00, edit_field = 0 while low and after release.
2. Bounce rejection: in HOUR, toggle btn_inc every cycle for 10 cycles, then hold high 10 cycles -> exactly one increment, hour 00 -> 01.
3. Time load with wrap:
   - mode, inc ×23 -> 23; inc -> 00; inc ×23 -> 23.
   - enter, inc ×59 -> 59; enter.
   - Expect load_time high exactly 120 cycles with digits 2,3,5,9; load_alarm 0 throughout; then edit_field = 0.
4. Alarm path and abort:
   - enter from IDLE -> edit_target = 1.
   - Set 06:30, enter -> load_alarm only, 120 cycles.
   - Repeat, pressing mode in MIN -> no strobe, edit_field = 0.
5. Auto-repeat: in MIN at 00, hold inc for REPEAT_DLY + 4·REPEAT_RATE cycles after the press event -> minute = 06.
6. Timeout and priority:
   - Enter HOUR, idle 3000 cycles -> edit_field = 0, no strobe.
   - Assert mode and inc in the same cycle in HOUR -> abort, hour unchanged.
